// File: rtl/rob_issue_sched.sv
// Issue scheduler for ROB entries: picks the oldest ready entry for a shared
// pipelined ALU and a non-pipelined memory unit, and drives one writeback port.
module rob_issue_sched #(
  parameter int ROB_SIZE     = 4,
  parameter int ROB_SIZE_LOG = 2,
  parameter int EX_LAT       = 1,
  parameter int MEM_LAT      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ROB_SIZE-1:0]     ready_vec,
  input  logic [ROB_SIZE-1:0]     mem_vec,
  input  logic [ROB_SIZE_LOG-1:0] rob_head,
  input  logic                    squash,
  output logic                    alu_issue_valid,
  output logic [ROB_SIZE_LOG-1:0] alu_issue_idx,
  output logic                    mem_issue_valid,
  output logic [ROB_SIZE_LOG-1:0] mem_issue_idx,
  output logic                    wb_valid,
  output logic [ROB_SIZE_LOG-1:0] wb_idx,
  output logic                    wb_is_mem
);

  localparam int CW = $clog2(MEM_LAT + 2);

  typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_e;

  logic [ROB_SIZE-1:0]     issued_q, issued_d;
  logic [EX_LAT-1:0]       pipe_v_q, pipe_v_d;
  logic [ROB_SIZE_LOG-1:0] pipe_idx_q [EX_LAT];
  logic [ROB_SIZE_LOG-1:0] pipe_idx_d [EX_LAT];
  mem_state_e              state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ROB_SIZE_LOG-1:0] mem_idx_q, mem_idx_d;

  logic [ROB_SIZE-1:0]     alu_cand, mem_cand;
  logic                    alu_found, mem_found;
  logic [ROB_SIZE_LOG-1:0] alu_pick, mem_pick, scan_idx;
  logic                    block, mem_busy, alu_wb, mem_wb;
  logic                    alu_slot_taken, same_lat_clash;

  // Scan from the head so the first hit is the oldest candidate.
  always_comb begin
    alu_cand  = ready_vec & ~issued_q & ~mem_vec;
    mem_cand  = ready_vec & ~issued_q & mem_vec;
    alu_found = 1'b0;
    mem_found = 1'b0;
    alu_pick  = '0;
    mem_pick  = '0;
    scan_idx  = '0;
    for (int k = 0; k < ROB_SIZE; k++) begin
      scan_idx = rob_head + ROB_SIZE_LOG'(k);
      if (!alu_found && alu_cand[scan_idx]) begin
        alu_found = 1'b1;
        alu_pick  = scan_idx;
      end
      if (!mem_found && mem_cand[scan_idx]) begin
        mem_found = 1'b1;
        mem_pick  = scan_idx;
      end
    end
  end

  // An ALU op issued when cnt==EX_LAT+1 would land on the memory writeback cycle.
  always_comb begin
    block           = rst || squash;
    mem_busy        = (state_q == MEM_BUSY);
    alu_wb          = pipe_v_q[EX_LAT-1];
    mem_wb          = mem_busy && (cnt_q == CW'(1));
    mem_issue_valid = !block && !mem_busy && mem_found;
    alu_slot_taken  = mem_busy && (cnt_q == CW'(EX_LAT + 1));
    same_lat_clash  = (MEM_LAT == EX_LAT) && mem_issue_valid;
    alu_issue_valid = !block && alu_found && !alu_slot_taken && !same_lat_clash;
    alu_issue_idx   = alu_issue_valid ? alu_pick : '0;
    mem_issue_idx   = mem_issue_valid ? mem_pick : '0;
    wb_valid        = !block && (alu_wb || mem_wb);
    wb_is_mem       = !block && mem_wb;
    wb_idx          = '0;
    if (!block) begin
      if (mem_wb)
        wb_idx = mem_idx_q;
      else if (alu_wb)
        wb_idx = pipe_idx_q[EX_LAT-1];
    end
  end

  always_comb begin
    issued_d = issued_q;
    if (alu_wb) issued_d[pipe_idx_q[EX_LAT-1]] = 1'b0;
    if (mem_wb) issued_d[mem_idx_q] = 1'b0;
    if (alu_issue_valid) issued_d[alu_issue_idx] = 1'b1;
    if (mem_issue_valid) issued_d[mem_issue_idx] = 1'b1;

    pipe_v_d      = pipe_v_q;
    pipe_idx_d    = pipe_idx_q;
    pipe_v_d[0]   = alu_issue_valid;
    pipe_idx_d[0] = alu_issue_idx;
    for (int k = 1; k < EX_LAT; k++) begin
      pipe_v_d[k]   = pipe_v_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_idx_d = mem_idx_q;
    case (state_q)
      MEM_IDLE: begin
        if (mem_issue_valid) begin
          state_d   = MEM_BUSY;
          cnt_d     = CW'(MEM_LAT);
          mem_idx_d = mem_pick;
        end
      end
      MEM_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase

    if (squash) begin
      issued_d = '0;
      pipe_v_d = '0;
      state_d  = MEM_IDLE;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      pipe_v_q <= '0;
      state_q  <= MEM_IDLE;
      cnt_q    <= '0;
    end else begin
      issued_q <= issued_d;
      pipe_v_q <= pipe_v_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
    pipe_idx_q <= pipe_idx_d;
    mem_idx_q  <= mem_idx_d;
  end

endmodule

// File: tb/tb_rob_issue_sched.sv
// Directed scoreboard bench for rob_issue_sched: each cycle's expected issue and
// writeback values are queued with the stimulus and checked on the falling edge.
module tb_rob_issue_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ready_vec, mem_vec;
  logic [1:0] rob_head;
  logic       squash;
  logic       alu_issue_valid, mem_issue_valid, wb_valid, wb_is_mem;
  logic [1:0] alu_issue_idx, mem_issue_idx, wb_idx;

  typedef struct {
    logic rs;
    int   av, ai, mv, mi, wv, wi, wm;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  rob_issue_sched #(.ROB_SIZE(4), .ROB_SIZE_LOG(2), .EX_LAT(1), .MEM_LAT(3)) dut (
    .clk(clk), .rst(rst), .ready_vec(ready_vec), .mem_vec(mem_vec),
    .rob_head(rob_head), .squash(squash),
    .alu_issue_valid(alu_issue_valid), .alu_issue_idx(alu_issue_idx),
    .mem_issue_valid(mem_issue_valid), .mem_issue_idx(mem_issue_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_is_mem(wb_is_mem)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue its expectations, compare on the falling edge.
  task automatic applyStimulus(input logic rs, input logic [3:0] rdy, input logic [3:0] memv,
                               input logic [1:0] head, input logic sq,
                               input int e_av, input int e_ai, input int e_mv, input int e_mi,
                               input int e_wv, input int e_wi, input int e_wm);
    exp_t e;
    rst       = rs;
    ready_vec = rdy;
    mem_vec   = memv;
    rob_head  = head;
    squash    = sq;
    e.rs = rs; e.av = e_av; e.ai = e_ai; e.mv = e_mv; e.mi = e_mi;
    e.wv = e_wv; e.wi = e_wi; e.wm = e_wm;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      checkOutput("alu_issue_valid", int'(alu_issue_valid), e.av);
      checkOutput("mem_issue_valid", int'(mem_issue_valid), e.mv);
      checkOutput("wb_valid", int'(wb_valid), e.wv);
      if (e.av != 0 || e.rs) checkOutput("alu_issue_idx", int'(alu_issue_idx), e.ai);
      if (e.mv != 0 || e.rs) checkOutput("mem_issue_idx", int'(mem_issue_idx), e.mi);
      if (e.wv != 0 || e.rs) begin
        checkOutput("wb_idx", int'(wb_idx), e.wi);
        checkOutput("wb_is_mem", int'(wb_is_mem), e.wm);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; ready_vec = '0; mem_vec = '0; rob_head = '0; squash = 1'b0;
    @(posedge clk);
    #1;
    // Reset held: everything quiet even with candidates present.
    applyStimulus(1, 4'b1111, 4'b0101, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(1, 4'b1111, 4'b0101, 2'd0, 0,  0,0, 0,0, 0,0,0);

    // Two ALU ops, oldest first, one-cycle writeback.
    applyStimulus(0, 4'b0110, 4'b0000, 2'd0, 0,  1,1, 0,0, 0,0,0);
    applyStimulus(0, 4'b0110, 4'b0000, 2'd0, 0,  1,2, 0,0, 1,1,0);
    applyStimulus(0, 4'b0100, 4'b0000, 2'd0, 0,  0,0, 0,0, 1,2,0);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0,  0,0, 0,0, 0,0,0);

    // Head wrap-around: head=3 prefers 3 over 0.
    applyStimulus(0, 4'b1001, 4'b0000, 2'd3, 0,  1,3, 0,0, 0,0,0);
    applyStimulus(0, 4'b1001, 4'b0000, 2'd3, 0,  1,0, 0,0, 1,3,0);
    applyStimulus(0, 4'b0001, 4'b0000, 2'd3, 0,  0,0, 0,0, 1,0,0);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd3, 0,  0,0, 0,0, 0,0,0);

    // Head=2: entry 0 (age 2) is older than entry 1 (age 3).
    applyStimulus(0, 4'b0011, 4'b0000, 2'd2, 0,  1,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0000, 2'd2, 0,  1,1, 0,0, 1,0,0);
    applyStimulus(0, 4'b0010, 4'b0000, 2'd2, 0,  0,0, 0,0, 1,1,0);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd2, 0,  0,0, 0,0, 0,0,0);

    // Memory latency 3 and back-to-back spacing of 4.
    applyStimulus(0, 4'b0001, 4'b0011, 2'd0, 0,  0,0, 1,0, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0011, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0011, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0011, 2'd0, 0,  0,0, 0,0, 1,0,1);
    applyStimulus(0, 4'b0010, 4'b0011, 2'd0, 0,  0,0, 1,1, 0,0,0);
    applyStimulus(0, 4'b0010, 4'b0011, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0010, 4'b0011, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0010, 4'b0011, 2'd0, 0,  0,0, 0,0, 1,1,1);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0,  0,0, 0,0, 0,0,0);

    // ALU suppressed when its writeback would collide with the memory one.
    applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 0,  0,0, 1,0, 0,0,0);
    applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0001, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0001, 2'd0, 0,  1,1, 0,0, 1,0,1);
    applyStimulus(0, 4'b0010, 4'b0001, 2'd0, 0,  0,0, 0,0, 1,1,0);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0,  0,0, 0,0, 0,0,0);

    // Squash with both units busy, entries re-readied right after.
    applyStimulus(0, 4'b0011, 4'b0010, 2'd0, 0,  1,0, 1,1, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0010, 2'd0, 1,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0010, 2'd0, 0,  1,0, 1,1, 0,0,0);
    applyStimulus(0, 4'b0010, 4'b0010, 2'd0, 0,  0,0, 0,0, 1,0,0);
    applyStimulus(0, 4'b0010, 4'b0010, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0010, 4'b0010, 2'd0, 0,  0,0, 0,0, 1,1,1);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0,  0,0, 0,0, 0,0,0);

    // Squash with nothing re-readied: in-flight ops never write back.
    applyStimulus(0, 4'b0011, 4'b0010, 2'd0, 0,  1,0, 1,1, 0,0,0);
    applyStimulus(0, 4'b0011, 4'b0010, 2'd0, 1,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0,  0,0, 0,0, 0,0,0);

    // Reset mid-flight (cnt=2), then reissue and let ready drop while in flight.
    applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 0,  0,0, 1,0, 0,0,0);
    applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(1, 4'b0001, 4'b0001, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0001, 4'b0001, 2'd0, 0,  0,0, 1,0, 0,0,0);
    applyStimulus(0, 4'b0000, 4'b0001, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0000, 4'b0001, 2'd0, 0,  0,0, 0,0, 0,0,0);
    applyStimulus(0, 4'b0000, 4'b0001, 2'd0, 0,  0,0, 0,0, 1,0,1);
    applyStimulus(0, 4'b0000, 4'b0000, 2'd0, 0,  0,0, 0,0, 0,0,0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
